rr_arb_mux_stage: RTL

//   Round-robin arbiter and output register stage in front of mux_param. Collects NUM_INPUT

---
 rtl/cryo_pipe_pkg.sv | 15 +
 rtl/mux_param.sv | 19 +
 rtl/rr_arb_mux_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/cryo_pipe_pkg.sv
// rtl/cryo_pipe_pkg.sv - shared widths, stage states and index helper for cryo pipeline stages
package cryo_pipe_pkg;

  localparam int RR_CNT_WIDTH = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_param.sv
// rtl/mux_param.sv - parameterised N:1 word mux; out-of-range select yields zero
module mux_param #(
  parameter int NUM_INPUT  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic [SEL_WIDTH-1:0]            sel,
  input  logic [DATA_WIDTH*NUM_INPUT-1:0] data_in,
  output logic [DATA_WIDTH-1:0]           data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (sel == SEL_WIDTH'(i)) data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/rr_arb_mux_stage.sv
// rtl/rr_arb_mux_stage.sv - round-robin arbiter plus registered output stage over mux_param
// grant_cnt port and counter exist only when RR_ARB_CNT_EN is defined
module rr_arb_mux_stage
  import cryo_pipe_pkg::*;
#(
  parameter int NUM_INPUT  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUT-1:0]            req_valid,
  output logic [NUM_INPUT-1:0]            req_ready,
  input  logic [DATA_WIDTH*NUM_INPUT-1:0] data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [SEL_WIDTH-1:0]            out_src
`ifdef RR_ARB_CNT_EN
  ,
  output logic [RR_CNT_WIDTH-1:0]         grant_cnt
`endif
);

  stage_state_e          state;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  grant;
  logic [DATA_WIDTH-1:0] mux_out;
  logic                  load;

  assign out_valid = (state == ST_FULL);
  assign load      = (|req_valid) & (~out_valid | out_ready);

  // Search wraps at NUM_INPUT so lanes beyond NUM_INPUT are never granted.
  always_comb begin : pick
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_INPUT) idx = idx - NUM_INPUT;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx[SEL_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      req_ready[i] = load & ~rst & (grant == SEL_WIDTH'(i));
    end
  end

  mux_param #(
    .NUM_INPUT (NUM_INPUT),
    .SEL_WIDTH (SEL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .sel     (grant),
    .data_in (data_in),
    .data_out(mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      data_out <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      state    <= ST_FULL;
      data_out <= mux_out;
      out_src  <= grant;
      ptr      <= SEL_WIDTH'(next_idx(int'(grant), NUM_INPUT));
    end else if (out_ready) begin
      state    <= ST_EMPTY;
    end
  end

`ifdef RR_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) grant_cnt <= '0;
    else if (load) grant_cnt <= grant_cnt + 1'b1;
  end
`endif

endmodule
